// File: rtl/tnoc_output_switch_if.sv
// Flit and port-control channel bundle between the five router input blocks
// and one output switch, plus the outgoing link toward the next hop.
interface tnoc_output_switch_if #(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 64
);
    logic [5*CHANNELS-1:0]            i_request;
    logic [5*CHANNELS-1:0]            o_grant;
    logic [5*CHANNELS-1:0]            i_valid;
    logic [5*CHANNELS-1:0]            o_ready;
    logic [5*CHANNELS-1:0]            i_tail;
    logic [5*CHANNELS*FLIT_WIDTH-1:0] i_flit;
    logic [CHANNELS-1:0]              o_valid;
    logic [CHANNELS-1:0]              i_ready;
    logic                             o_tail;
    logic [FLIT_WIDTH-1:0]            o_flit;

    // Input blocks and the downstream link side
    modport master (
        output i_request, i_valid, i_tail, i_flit, i_ready,
        input  o_grant, o_ready, o_valid, o_tail, o_flit
    );

    // Output switch side
    modport slave (
        input  i_request, i_valid, i_tail, i_flit, i_ready,
        output o_grant, o_ready, o_valid, o_tail, o_flit
    );
endinterface

// File: rtl/tnoc_output_switch.sv
// Router output stage: per-VC round-robin arbitration among the five input
// ports with the winner locked for a whole packet, and flit-by-flit VC
// interleaving into a single registered output slot.
module tnoc_output_switch #(
    parameter int         CHANNELS        = 2,
    parameter int         FLIT_WIDTH      = 64,
    parameter logic [4:0] AVAILABLE_PORTS = 5'b11111
) (
    input logic                 clk,
    input logic                 rst_n,
    tnoc_output_switch_if.slave bus
);
    localparam int PORTS = 5;
    localparam int PC    = PORTS * CHANNELS;
    localparam int VC_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    // Per-VC owner state
    logic [CHANNELS-1:0][0:0] state;
    logic [CHANNELS-1:0][2:0] owner;
    logic [CHANNELS-1:0][2:0] port_ptr;

    // Output slot and VC interleave pointer
    logic [VC_W-1:0]       vc_ptr;
    logic [CHANNELS-1:0]   valid_q;
    logic [VC_W-1:0]       slot_vc;
    logic                  tail_q;
    logic [FLIT_WIDTH-1:0] flit_q;

    // Combinational decisions
    logic [PC-1:0]            masked_req;
    logic [CHANNELS-1:0]      arb_found;
    logic [CHANNELS-1:0][2:0] arb_winner;
    logic [PC-1:0]            grant;
    logic [CHANNELS-1:0]      cand;
    logic                     loadable;
    logic                     pick_found;
    logic [VC_W-1:0]          pick_vc;
    logic                     load;
    logic                     pick_tail;
    logic [FLIT_WIDTH-1:0]    pick_flit;
    logic [CHANNELS-1:0]      pick_onehot;
    logic [PC-1:0]            ready;

    function automatic logic [2:0] next_port(input int base, input int k);
        int s;
        s = base + k;
        if (s >= PORTS) s = s - PORTS;
        return 3'(s);
    endfunction

    function automatic logic [VC_W-1:0] next_vc(input int base, input int k);
        int s;
        s = base + k;
        if (s >= CHANNELS) s = s - CHANNELS;
        return VC_W'(s);
    endfunction

    // Disabled input ports can never take part in arbitration
    always_comb begin
        masked_req = '0;
        for (int p = 0; p < PORTS; p++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                masked_req[p*CHANNELS+c] = bus.i_request[p*CHANNELS+c] & AVAILABLE_PORTS[p];
            end
        end
    end

    // Round-robin port search per idle VC, starting at the port after the last winner
    always_comb begin
        arb_found  = '0;
        arb_winner = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (state[c] == IDLE) begin
                for (int k = 0; k < PORTS; k++) begin
                    if (!arb_found[c] &&
                        masked_req[int'(next_port(int'(port_ptr[c]), k))*CHANNELS + c]) begin
                        arb_found[c]  = 1'b1;
                        arb_winner[c] = next_port(int'(port_ptr[c]), k);
                    end
                end
            end
        end
    end

    // Grants follow the registered owner of every locked VC
    always_comb begin
        grant = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int p = 0; p < PORTS; p++) begin
                grant[p*CHANNELS+c] = (state[c] == LOCKED) && (owner[c] == 3'(p));
            end
        end
    end

    // A VC competes for the slot when it is locked and its owner has a flit ready
    always_comb begin
        cand = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cand[c] = (state[c] == LOCKED) && bus.i_valid[int'(owner[c])*CHANNELS + c];
        end
    end

    assign loadable = (valid_q == '0) || bus.i_ready[slot_vc];

    // Pick one candidate VC round-robin and accept exactly that owner's flit
    always_comb begin
        pick_found  = 1'b0;
        pick_vc     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!pick_found && cand[int'(next_vc(int'(vc_ptr), k))]) begin
                pick_found = 1'b1;
                pick_vc    = next_vc(int'(vc_ptr), k);
            end
        end
        load        = loadable && pick_found;
        pick_flit   = bus.i_flit[(int'(owner[pick_vc])*CHANNELS + int'(pick_vc))*FLIT_WIDTH +: FLIT_WIDTH];
        pick_tail   = bus.i_tail[int'(owner[pick_vc])*CHANNELS + int'(pick_vc)];
        pick_onehot = '0;
        pick_onehot[pick_vc] = 1'b1;
        ready       = '0;
        if (load) begin
            ready[int'(owner[pick_vc])*CHANNELS + int'(pick_vc)] = 1'b1;
        end
    end

    // Owner FSM per VC: lock on a win, release when the owner's tail is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= {CHANNELS{IDLE}};
            owner    <= '0;
            port_ptr <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (state[c] == IDLE) begin
                    if (arb_found[c]) begin
                        state[c]    <= LOCKED;
                        owner[c]    <= arb_winner[c];
                        port_ptr[c] <= next_port(int'(arb_winner[c]), 1);
                    end
                end else if (load && (int'(pick_vc) == c) && pick_tail) begin
                    state[c] <= IDLE;
                end
            end
        end
    end

    // Output slot: refill on drain for full throughput, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vc_ptr  <= '0;
            valid_q <= '0;
            slot_vc <= '0;
            tail_q  <= 1'b0;
            flit_q  <= '0;
        end else if (load) begin
            vc_ptr  <= next_vc(int'(pick_vc), 1);
            valid_q <= pick_onehot;
            slot_vc <= pick_vc;
            tail_q  <= pick_tail;
            flit_q  <= pick_flit;
        end else if (loadable) begin
            valid_q <= '0;
        end
    end

    assign bus.o_grant = grant;
    assign bus.o_ready = ready;
    assign bus.o_valid = valid_q;
    assign bus.o_tail  = tail_q;
    assign bus.o_flit  = flit_q;
endmodule

// File: tb/tb_tnoc_output_switch.sv
// Directed bench for tnoc_output_switch: two VCs, 16-bit flits. Upstream
// sources present flits {source index, sequence} and advance when accepted.
module tb_tnoc_output_switch;
    localparam int CH   = 2;
    localparam int FW   = 16;
    localparam int NSRC = 5 * CH;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    int rem [NSRC];
    int seq [NSRC];
    logic [NSRC-1:0] ready_cap;

    tnoc_output_switch_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) bus1 ();
    tnoc_output_switch_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) bus2 ();

    tnoc_output_switch #(
        .CHANNELS(CH), .FLIT_WIDTH(FW), .AVAILABLE_PORTS(5'b11111)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    tnoc_output_switch #(
        .CHANNELS(CH), .FLIT_WIDTH(FW), .AVAILABLE_PORTS(5'b10111)
    ) dut_masked (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_sources();
        for (int s = 0; s < NSRC; s++) begin
            bus1.i_request[s]       = (rem[s] > 0);
            bus1.i_valid[s]         = (rem[s] > 0);
            bus1.i_tail[s]          = (rem[s] == 1);
            bus1.i_flit[s*FW +: FW] = 16'((s << 8) | seq[s]);
        end
    endtask

    task automatic load_source(input int s, input int len);
        rem[s] = len;
        seq[s] = 0;
    endtask

    task automatic clear_sources();
        for (int s = 0; s < NSRC; s++) begin
            rem[s] = 0;
            seq[s] = 0;
        end
    endtask

    // One clock: capture accepts on the falling edge, advance sources after the rising edge
    task automatic step();
        @(negedge clk);
        ready_cap = bus1.o_ready;
        @(posedge clk);
        #1;
        for (int s = 0; s < NSRC; s++) begin
            if (ready_cap[s] && rem[s] > 0) begin
                rem[s] = rem[s] - 1;
                seq[s] = seq[s] + 1;
            end
        end
        drive_sources();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_sources();
        bus1.i_ready = 2'b11;
        bus2.i_request = '0;
        bus2.i_valid   = '0;
        bus2.i_tail    = '0;
        bus2.i_flit    = '0;
        bus2.i_ready   = 2'b11;
        load_source(0, 1);
        drive_sources();
        #3;
        checks++;
        if (bus1.o_grant !== 10'h000) begin errors++; $display("[TB] FAIL reset_grant: got %h expected 000", bus1.o_grant); end
        checks++;
        if (bus1.o_ready !== 10'h000) begin errors++; $display("[TB] FAIL reset_ready: got %h expected 000", bus1.o_ready); end
        checks++;
        if (bus1.o_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 00", bus1.o_valid); end
        checks++;
        if (bus1.o_tail !== 1'b0) begin errors++; $display("[TB] FAIL reset_tail: got %b expected 0", bus1.o_tail); end
        checks++;
        if (bus1.o_flit !== 16'h0000) begin errors++; $display("[TB] FAIL reset_flit: got %h expected 0000", bus1.o_flit); end
        checks++;
        if (bus2.o_grant !== 10'h000) begin errors++; $display("[TB] FAIL reset_grant_masked: got %h expected 000", bus2.o_grant); end
        clear_sources();
        drive_sources();
        #19;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_single_port();
        logic [9:0]  eg [6] = '{10'h000, 10'h100, 10'h100, 10'h100, 10'h000, 10'h000};
        logic [9:0]  er [6] = '{10'h000, 10'h100, 10'h100, 10'h100, 10'h000, 10'h000};
        logic [1:0]  ev [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        logic [15:0] ef [6] = '{16'h0, 16'h0, 16'h0800, 16'h0801, 16'h0802, 16'h0};
        logic        et [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus1.i_ready = 2'b11;
        load_source(8, 3);
        drive_sources();
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            checks++;
            if (bus1.o_grant !== eg[i]) begin errors++; $display("[TB] FAIL single_grant[%0d]: got %h expected %h", i, bus1.o_grant, eg[i]); end
            checks++;
            if (bus1.o_ready !== er[i]) begin errors++; $display("[TB] FAIL single_ready[%0d]: got %h expected %h", i, bus1.o_ready, er[i]); end
            checks++;
            if (bus1.o_valid !== ev[i]) begin errors++; $display("[TB] FAIL single_valid[%0d]: got %b expected %b", i, bus1.o_valid, ev[i]); end
            if (ev[i] != 2'b00) begin
                checks++;
                if (bus1.o_flit !== ef[i]) begin errors++; $display("[TB] FAIL single_flit[%0d]: got %h expected %h", i, bus1.o_flit, ef[i]); end
                checks++;
                if (bus1.o_tail !== et[i]) begin errors++; $display("[TB] FAIL single_tail[%0d]: got %b expected %b", i, bus1.o_tail, et[i]); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [9:0]  eg [11] = '{10'h000, 10'h002, 10'h002, 10'h000, 10'h020, 10'h020,
                                 10'h000, 10'h200, 10'h200, 10'h000, 10'h000};
        logic [9:0]  er [11] = '{10'h000, 10'h002, 10'h002, 10'h000, 10'h020, 10'h020,
                                 10'h000, 10'h200, 10'h200, 10'h000, 10'h000};
        logic [1:0]  ev [11] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10,
                                 2'b10, 2'b00, 2'b10, 2'b10, 2'b00};
        logic [15:0] ef [11] = '{16'h0, 16'h0, 16'h0100, 16'h0101, 16'h0, 16'h0500,
                                 16'h0501, 16'h0, 16'h0900, 16'h0901, 16'h0};
        logic        et [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        load_source(1, 2);
        load_source(5, 2);
        load_source(9, 2);
        drive_sources();
        #1;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) step();
            checks++;
            if (bus1.o_grant !== eg[i]) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %h expected %h", i, bus1.o_grant, eg[i]); end
            checks++;
            if (bus1.o_ready !== er[i]) begin errors++; $display("[TB] FAIL rr_ready[%0d]: got %h expected %h", i, bus1.o_ready, er[i]); end
            checks++;
            if (bus1.o_valid !== ev[i]) begin errors++; $display("[TB] FAIL rr_valid[%0d]: got %b expected %b", i, bus1.o_valid, ev[i]); end
            if (ev[i] != 2'b00) begin
                checks++;
                if (bus1.o_flit !== ef[i]) begin errors++; $display("[TB] FAIL rr_flit[%0d]: got %h expected %h", i, bus1.o_flit, ef[i]); end
                checks++;
                if (bus1.o_tail !== et[i]) begin errors++; $display("[TB] FAIL rr_tail[%0d]: got %b expected %b", i, bus1.o_tail, et[i]); end
            end
        end
    endtask

    task automatic test_interleave();
        logic [9:0]  eg [11] = '{10'h000, 10'h081, 10'h081, 10'h081, 10'h081, 10'h081,
                                 10'h081, 10'h081, 10'h080, 10'h000, 10'h000};
        logic [9:0]  er [11] = '{10'h000, 10'h001, 10'h080, 10'h001, 10'h080, 10'h001,
                                 10'h080, 10'h001, 10'h080, 10'h000, 10'h000};
        logic [1:0]  ev [11] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10,
                                 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [15:0] ef [11] = '{16'h0, 16'h0, 16'h0000, 16'h0700, 16'h0001, 16'h0701,
                                 16'h0002, 16'h0702, 16'h0003, 16'h0703, 16'h0};
        logic        et [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        load_source(0, 4);
        load_source(7, 4);
        drive_sources();
        #1;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) step();
            checks++;
            if (bus1.o_grant !== eg[i]) begin errors++; $display("[TB] FAIL ilv_grant[%0d]: got %h expected %h", i, bus1.o_grant, eg[i]); end
            checks++;
            if (bus1.o_ready !== er[i]) begin errors++; $display("[TB] FAIL ilv_ready[%0d]: got %h expected %h", i, bus1.o_ready, er[i]); end
            checks++;
            if (bus1.o_valid !== ev[i]) begin errors++; $display("[TB] FAIL ilv_valid[%0d]: got %b expected %b", i, bus1.o_valid, ev[i]); end
            if (ev[i] != 2'b00) begin
                checks++;
                if (bus1.o_flit !== ef[i]) begin errors++; $display("[TB] FAIL ilv_flit[%0d]: got %h expected %h", i, bus1.o_flit, ef[i]); end
                checks++;
                if (bus1.o_tail !== et[i]) begin errors++; $display("[TB] FAIL ilv_tail[%0d]: got %b expected %b", i, bus1.o_tail, et[i]); end
            end
        end
    endtask

    task automatic test_stall();
        logic [9:0]  eg [7] = '{10'h000, 10'h021, 10'h021, 10'h021, 10'h021, 10'h021, 10'h021};
        logic [9:0]  er [7] = '{10'h000, 10'h001, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
        logic [1:0]  ev [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        logic [9:0]  eg2 [3] = '{10'h021, 10'h020, 10'h000};
        logic [9:0]  er2 [3] = '{10'h001, 10'h020, 10'h000};
        logic [1:0]  ev2 [3] = '{2'b10, 2'b01, 2'b10};
        logic [15:0] ef2 [3] = '{16'h0500, 16'h0001, 16'h0501};
        logic        et2 [3] = '{1'b0, 1'b1, 1'b1};
        bus1.i_ready = 2'b10;
        load_source(0, 2);
        load_source(5, 2);
        drive_sources();
        #1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            checks++;
            if (bus1.o_grant !== eg[i]) begin errors++; $display("[TB] FAIL stall_grant[%0d]: got %h expected %h", i, bus1.o_grant, eg[i]); end
            checks++;
            if (bus1.o_ready !== er[i]) begin errors++; $display("[TB] FAIL stall_ready[%0d]: got %h expected %h", i, bus1.o_ready, er[i]); end
            checks++;
            if (bus1.o_valid !== ev[i]) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %b expected %b", i, bus1.o_valid, ev[i]); end
            if (ev[i] != 2'b00) begin
                checks++;
                if (bus1.o_flit !== 16'h0000) begin errors++; $display("[TB] FAIL stall_flit[%0d]: got %h expected 0000", i, bus1.o_flit); end
            end
        end
        bus1.i_ready = 2'b11;
        #1;
        checks++;
        if (bus1.o_ready !== 10'h020) begin errors++; $display("[TB] FAIL stall_release_ready: got %h expected 020", bus1.o_ready); end
        checks++;
        if (bus1.o_valid !== 2'b01) begin errors++; $display("[TB] FAIL stall_release_valid: got %b expected 01", bus1.o_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus1.o_grant !== eg2[i]) begin errors++; $display("[TB] FAIL drain_grant[%0d]: got %h expected %h", i, bus1.o_grant, eg2[i]); end
            checks++;
            if (bus1.o_ready !== er2[i]) begin errors++; $display("[TB] FAIL drain_ready[%0d]: got %h expected %h", i, bus1.o_ready, er2[i]); end
            checks++;
            if (bus1.o_valid !== ev2[i]) begin errors++; $display("[TB] FAIL drain_valid[%0d]: got %b expected %b", i, bus1.o_valid, ev2[i]); end
            checks++;
            if (bus1.o_flit !== ef2[i]) begin errors++; $display("[TB] FAIL drain_flit[%0d]: got %h expected %h", i, bus1.o_flit, ef2[i]); end
            checks++;
            if (bus1.o_tail !== et2[i]) begin errors++; $display("[TB] FAIL drain_tail[%0d]: got %b expected %b", i, bus1.o_tail, et2[i]); end
        end
    endtask

    task automatic test_masked_port();
        bus2.i_request = 10'h040;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++;
            if (bus2.o_grant !== 10'h000) begin errors++; $display("[TB] FAIL mask_ym_grant[%0d]: got %h expected 000", i, bus2.o_grant); end
        end
        bus2.i_request = 10'h140;
        #1;
        checks++;
        if (bus2.o_grant !== 10'h000) begin errors++; $display("[TB] FAIL mask_pre_grant: got %h expected 000", bus2.o_grant); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus2.o_grant !== 10'h100) begin errors++; $display("[TB] FAIL mask_l_grant[%0d]: got %h expected 100", i, bus2.o_grant); end
            checks++;
            if (bus2.o_ready !== 10'h000) begin errors++; $display("[TB] FAIL mask_ready[%0d]: got %h expected 000", i, bus2.o_ready); end
        end
        checks++;
        if (bus2.o_valid !== 2'b00) begin errors++; $display("[TB] FAIL mask_valid: got %b expected 00", bus2.o_valid); end
    endtask

    task automatic test_reset_mid_packet();
        logic [9:0]  eg [5] = '{10'h000, 10'h001, 10'h000, 10'h010, 10'h000};
        logic [9:0]  er [5] = '{10'h000, 10'h001, 10'h000, 10'h010, 10'h000};
        logic [1:0]  ev [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
        logic [15:0] ef [5] = '{16'h0, 16'h0, 16'h0000, 16'h0, 16'h0400};
        load_source(2, 4);
        drive_sources();
        #1;
        step();
        checks++;
        if (bus1.o_grant !== 10'h004) begin errors++; $display("[TB] FAIL rstmid_grant: got %h expected 004", bus1.o_grant); end
        step();
        step();
        checks++;
        if (bus1.o_flit !== 16'h0201) begin errors++; $display("[TB] FAIL rstmid_flit: got %h expected 0201", bus1.o_flit); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus1.o_grant !== 10'h000) begin errors++; $display("[TB] FAIL rstmid_async_grant: got %h expected 000", bus1.o_grant); end
        checks++;
        if (bus1.o_valid !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_async_valid: got %b expected 00", bus1.o_valid); end
        checks++;
        if (bus1.o_ready !== 10'h000) begin errors++; $display("[TB] FAIL rstmid_async_ready: got %h expected 000", bus1.o_ready); end
        clear_sources();
        drive_sources();
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        load_source(0, 1);
        load_source(4, 1);
        drive_sources();
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            checks++;
            if (bus1.o_grant !== eg[i]) begin errors++; $display("[TB] FAIL post_rst_grant[%0d]: got %h expected %h", i, bus1.o_grant, eg[i]); end
            checks++;
            if (bus1.o_ready !== er[i]) begin errors++; $display("[TB] FAIL post_rst_ready[%0d]: got %h expected %h", i, bus1.o_ready, er[i]); end
            checks++;
            if (bus1.o_valid !== ev[i]) begin errors++; $display("[TB] FAIL post_rst_valid[%0d]: got %b expected %b", i, bus1.o_valid, ev[i]); end
            if (ev[i] != 2'b00) begin
                checks++;
                if (bus1.o_flit !== ef[i]) begin errors++; $display("[TB] FAIL post_rst_flit[%0d]: got %h expected %h", i, bus1.o_flit, ef[i]); end
                checks++;
                if (bus1.o_tail !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_tail[%0d]: got %b expected 1", i, bus1.o_tail); end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ready_cap = '0;
        test_reset();
        test_single_port();
        test_round_robin();
        test_interleave();
        test_stall();
        test_masked_port();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tnoc_output_switch.md
Name: tnoc_output_switch

Overview:
- Router output stage. It is the consumer end of the per-direction flit and port-control channels that the five input blocks of a router drive toward one output direction.
- Per virtual channel, it arbitrates round-robin among the five input ports and locks the winner for a whole packet.
- It interleaves flits of different VCs flit-by-flit and registers the selected flit onto the output link.
- One instance is placed per output direction (xp, xm, yp, ym, l).

Parameters:
- CHANNELS, 2, number of virtual channels (1..8).
- FLIT_WIDTH, 64, flit payload width in bits (tail indication is separate).
- AVAILABLE_PORTS, 5'b11111, input-port enable mask. Bit order: 0=xp, 1=xm, 2=yp, 3=ym, 4=l. Disabled ports are never granted.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low. One clock domain only.
- i_request  in  5*CHANNELS  per (port p, vc c) request, at bit p*CHANNELS+c. Asserted with a head flit pending.
- o_grant  out  5*CHANNELS  port p owns VC c. Same bit indexing as i_request.
- i_valid  in  5*CHANNELS  flit valid per (p,c).
- o_ready  out  5*CHANNELS  flit accepted per (p,c).
- i_tail  in  5*CHANNELS  flit at (p,c) is the packet's last flit.
- i_flit  in  5*CHANNELS*FLIT_WIDTH  flit data per (p,c), at slice (p*CHANNELS+c)*FLIT_WIDTH.
- o_valid  out  CHANNELS  output flit valid, at most one bit set (its VC).
- i_ready  in  CHANNELS  downstream ready per VC.
- o_tail  out  1  output flit is a tail.
- o_flit  out  FLIT_WIDTH  output flit data.

Behaviour:
- Reset values: o_grant=0, o_valid=0, o_tail=0, o_flit=0. All port round-robin pointers=port 0; VC pointer=VC 0. o_ready is combinational and is 0 during reset because no grants exist.
- Per-VC owner FSM, states IDLE and LOCKED:
  - IDLE: masked requests (i_request & AVAILABLE_PORTS) for VC c are arbitrated round-robin, starting at the port after the last winner.
  - The winner is registered at the clock edge; o_grant for (winner,c) goes high the next cycle and the FSM moves to LOCKED.
  - LOCKED: o_grant is held, and i_request is ignored.
  - LOCKED -> IDLE on the edge where the owner's flit with i_tail=1 is accepted. o_grant drops the following cycle.
  - Re-arbitration happens in that following IDLE cycle. Minimum gap from tail accept to the next grant is one idle cycle.
  - A request that drops while the FSM is IDLE is simply not considered; there is no sticky state.
- Output slot: a single register holding valid, vc, tail and flit.
  - The slot is loadable when it is empty, or when i_ready[slot_vc]=1 (drain and refill in the same cycle, full throughput).
  - Candidate VCs are those in LOCKED whose owner has i_valid=1.
  - When the slot is loadable, one candidate is picked round-robin by the VC pointer. The pointer advances past the picked VC.
  - o_ready is 1 only for (owner,picked VC) in a load cycle, and 0 everywhere else.
  - On load, o_valid gets one-hot(picked VC); o_flit and o_tail are copied from the input.
  - Not loadable: all o_ready=0 and the slot holds (o_valid, o_flit and o_tail stable while stalled).
  - Drained with no candidate: o_valid -> 0.
- Latency:
  - request at cycle N -> grant at N+1 -> flit accepted at N+1 (if valid) -> o_valid at N+2.
  - Steady state is 1 flit per cycle.
- Boundary cases:
  - Single-flit packet: head and tail in one flit. It is accepted in the first grant cycle, which also releases the FSM.
  - A tail accepted while another port requests the same VC: that port wins if it is next in round-robin order.
  - Unowned VCs never produce o_ready.
  - Downstream ready on a VC other than slot_vc has no effect.
  - rst_n asserted mid-packet: all grants are cleared immediately (asynchronous), the slot is emptied and pointers are reset. A partial packet is discarded by system reset.

Test Plan:
1. Reset, then port l requests VC0 with a 3-flit packet, i_ready=all 1 -> grant[4*CH+0]=1 at N+1; o_valid=2'b01 on N+2..N+4 with flits in order; o_tail=1 on N+4; grant drops at N+4.
2. Ports xp, yp, l request VC1 together, 2-flit packets each, continuous -> packets are granted in order xp, yp, l. Each packet is contiguous on VC1, with one idle cycle between packets.
3. xp owns VC0 and ym owns VC1, both streaming -> o_valid alternates 01,10,01,10. No flit is lost or duplicated, and per-VC order is preserved.
4. Slot holds a VC0 flit with i_ready[0]=0 for 5 cycles -> o_flit and o_valid stay stable and all o_ready=0. i_ready[0]=1 -> a VC1 candidate loads the same cycle the VC0 flit drains.
5. AVAILABLE_PORTS=5'b10111 and ym requests VC0 -> no grant ever. A simultaneous l request is granted normally.
6. rst_n pulsed low in the middle of a 4-flit packet -> o_grant and o_valid are 0 asynchronously. After release, a new request is granted starting from port 0 priority.
